// File: rtl/rr_mux4_arbiter_if.sv
// rr_mux4_arbiter_if: request/data/grant bundle between four requesters and the shared-channel arbiter.
interface rr_mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] I;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       Y;
  modport master (output req, I, input gnt, sel, valid, Y);
  modport slave  (input req, I, output gnt, sel, valid, Y);
endinterface

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin arbiter sharing one 4:1 mux channel, with a hold limit per grant.
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input logic clk,
  input logic rst,
  rr_mux4_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         ptr;
  logic [3:0]         gnt_r;
  logic [1:0]         sel_r;
  logic               valid_r;
  logic               first_f, other_f, rel, at_limit;
  logic [1:0]         first_w, other_w;
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction
  // The handoff search excludes the current owner so a hold-limit rotation never re-picks it.
  always_comb begin
    {first_f, first_w} = pick(bus.req, ptr);
    {other_f, other_w} = pick(bus.req & ~(4'b0001 << sel_r), sel_r + 2'd1);
    rel      = ~bus.req[sel_r];
    at_limit = cnt == CNT_W'(MAX_HOLD - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      gnt_r   <= '0;
      sel_r   <= '0;
      valid_r <= 1'b0;
    end else if (state == IDLE) begin
      if (first_f) begin
        state   <= GRANT;
        sel_r   <= first_w;
        gnt_r   <= 4'b0001 << first_w;
        valid_r <= 1'b1;
        cnt     <= '0;
      end
    end else if (rel || at_limit) begin
      ptr <= sel_r + 2'd1;
      cnt <= '0;
      if (other_f) begin
        sel_r <= other_w;
        gnt_r <= 4'b0001 << other_w;
      end else if (rel) begin
        state   <= IDLE;
        gnt_r   <= '0;
        valid_r <= 1'b0;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign bus.gnt   = gnt_r;
  assign bus.sel   = sel_r;
  assign bus.valid = valid_r;
  assign bus.Y     = valid_r & bus.I[sel_r];
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: randomized and directed stimulus against a queue-based scoreboard and reference model.
module tb_rr_mux4_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_mux4_arbiter_if bus();
  rr_mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int owner = -1, held = 0, ptr = 0, last = 0;
  function automatic int find(input logic [3:0] q, input int start, input int n, input int excl);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (q[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction
  task automatic model(input logic r, input logic [3:0] q);
    exp_t e;
    int w;
    if (r) begin
      owner = -1; held = 0; ptr = 0; last = 0;
    end else if (owner < 0) begin
      w = find(q, ptr, 4, -1);
      if (w >= 0) begin owner = w; held = 1; last = w; end
    end else if (!q[owner] || held == MAX_HOLD) begin
      ptr = (owner + 1) % 4;
      w = find(q, ptr, 3, owner);
      if (w >= 0) begin owner = w; held = 1; last = w; end
      else if (!q[owner]) owner = -1;
      else held = 1;
    end else begin
      held++;
    end
    e.valid = owner >= 0;
    e.gnt   = e.valid ? 4'(1 << owner) : 4'b0000;
    e.sel   = 2'(last);
    exp_q.push_back(e);
  endtask
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d);
    @(negedge clk);
    rst = r; bus.req = q; bus.I = d;
    model(r, q);
  endtask
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req_v);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic y_exp;
      e = exp_q.pop_front();
      y_exp = e.valid & bus.I[e.sel];
      check("gnt", bus.gnt, e.gnt);
      check("sel", {2'b00, bus.sel}, {2'b00, e.sel});
      check("valid", {3'b000, bus.valid}, {3'b000, e.valid});
      check("Y", {3'b000, bus.Y}, {3'b000, y_exp});
      check("valid_eq_or_gnt", {3'b000, bus.valid}, {3'b000, |bus.gnt});
    end
  end
  initial begin
    bus.req = '0; bus.I = '0;
    repeat (2) step(1'b1, 4'b1111, 4'b1111);
    repeat (22) step(1'b0, 4'b1111, 4'($urandom));
    step(1'b1, 4'b0000, 4'b0000);
    repeat (10) step(1'b0, 4'b0100, 4'b0100);
    repeat (2) step(1'b0, 4'b0000, 4'b0100);
    repeat (2) step(1'b0, 4'b0010, 4'($urandom));
    step(1'b0, 4'b1010, 4'($urandom));
    repeat (3) step(1'b0, 4'b1000, 4'($urandom));
    step(1'b0, 4'b0000, 4'b0000);
    repeat (12) step(1'b0, 4'b0010, 4'($urandom));
    step(1'b0, 4'b0000, 4'b0000);
    repeat (3) step(1'b0, 4'b0100, 4'($urandom));
    step(1'b1, 4'b0100, 4'($urandom));
    repeat (3) step(1'b0, 4'b0101, 4'($urandom));
    repeat (400) step($urandom_range(0, 49) == 0, 4'($urandom), 4'($urandom));
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
